// File: rtl/ins_mem_loader.sv
// ins_mem_loader: streams bytes into instruction memory.
// Four bytes are packed MSB-first into one 32-bit instruction word.
// Each word is written at the next word address, starting from a programmable base.
// The fetch pipeline is held until the whole program has been written.
module ins_mem_loader #(
   parameter int DEPTH = 256,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_adrr,
   input  logic [15:0]   num_words,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic [AW-1:0] w_adrr,
   output logic [31:0]   w_data,
   output logic          m_w,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          wrap_err,
   output logic [15:0]   words_written
);

   // Byte address of the last word in memory; the address after it is 0.
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH * 4 - 4);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_FINISH  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [1:0]    r_byte_cnt;
   logic [15:0]   r_num_words;
   logic [15:0]   r_words;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_data;
   logic          r_wrap;
   logic          r_m_w;
   logic          r_done;
   logic          r_busy;
   logic          r_in_ready;
   logic          w_xfer;
   logic          w_last_word;

   // r_in_ready is high exactly while in COLLECT, so it qualifies the handshake.
   assign w_xfer      = (r_state == S_COLLECT) && in_valid && r_in_ready;
   assign w_last_word = ((r_words + 16'd1) == r_num_words);

   assign in_ready      = r_in_ready;
   assign w_adrr        = r_addr;
   assign w_data        = r_data;
   assign m_w           = r_m_w;
   assign cpu_hold      = r_busy;
   assign busy          = r_busy;
   assign done          = r_done;
   assign wrap_err      = r_wrap;
   assign words_written = r_words;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. In COLLECT, abort wins over a simultaneous byte transfer.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (num_words == 16'd0) begin
                  w_next_state = S_FINISH;
               end else begin
                  w_next_state = S_COLLECT;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_COLLECT: begin
            if (abort) begin
               w_next_state = S_FINISH;
            end else if (w_xfer && (r_byte_cnt == 2'd3)) begin
               w_next_state = S_WRITE;
            end else begin
               w_next_state = S_COLLECT;
            end
         end
         S_WRITE: begin
            if (abort || w_last_word) begin
               w_next_state = S_FINISH;
            end else begin
               w_next_state = S_COLLECT;
            end
         end
         S_FINISH: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Datapath: latch load parameters, assemble bytes, advance the address after each write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_byte_cnt  <= 2'd0;
         r_num_words <= 16'd0;
         r_words     <= 16'd0;
         r_addr      <= '0;
         r_data      <= 32'd0;
         r_wrap      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr      <= {base_adrr[AW-1:2], 2'b00};
                  r_num_words <= num_words;
                  r_words     <= 16'd0;
                  r_wrap      <= 1'b0;
                  r_byte_cnt  <= 2'd0;
               end
            end
            S_COLLECT: begin
               if (abort) begin
                  // Drop the partial word; the next load starts at byte 0.
                  r_byte_cnt <= 2'd0;
               end else if (w_xfer) begin
                  case (r_byte_cnt)
                     2'd0:    r_data[31:24] <= in_data;
                     2'd1:    r_data[23:16] <= in_data;
                     2'd2:    r_data[15:8]  <= in_data;
                     default: r_data[7:0]   <= in_data;
                  endcase
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
            end
            S_WRITE: begin
               r_words <= r_words + 16'd1;
               if (r_addr == LAST_ADDR) begin
                  r_addr <= '0;
                  r_wrap <= 1'b1;
               end else begin
                  r_addr <= r_addr + AW'(4);
               end
            end
            default: begin
               r_byte_cnt <= r_byte_cnt;
            end
         endcase
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m_w      <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_m_w      <= (w_next_state == S_WRITE);
         r_done     <= (w_next_state == S_FINISH);
         r_busy     <= (w_next_state == S_COLLECT) || (w_next_state == S_WRITE);
         r_in_ready <= (w_next_state == S_COLLECT);
      end
   end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Testbench for ins_mem_loader.
// Random byte streams are driven into the loader.
// The expected writes are computed from the load rules:
// word i goes to ((base & ~3) + 4*i) mod (DEPTH*4) and holds bytes 4i..4i+3, MSB first.
// Expected handshake, strobe and done timing are tracked cycle by cycle.
module tb_ins_mem_loader;

   localparam int DEPTH = 256;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_adrr;
   logic [15:0]   num_words;
   logic          abort;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic [AW-1:0] w_adrr;
   logic [31:0]   w_data;
   logic          m_w;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic          wrap_err;
   logic [15:0]   words_written;

   int total = 0;
   int bad   = 0;

   logic [7:0]  stim [0:63];
   logic [31:0] got_a [$];
   logic [31:0] got_d [$];

   ins_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_adrr(base_adrr),
      .num_words(num_words), .abort(abort), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .w_adrr(w_adrr), .w_data(w_data), .m_w(m_w),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .wrap_err(wrap_err),
      .words_written(words_written)
   );

   always #5 clk = ~clk;

   task automatic fill_random();
      for (int i = 0; i < 64; i++) stim[i] = 8'($urandom_range(0, 255));
   endtask

   // gap_mode: 0 = valid every cycle, 1 = random valid, 2 = valid toggles every cycle.
   // abort_at / restart_at: byte count at which abort or a second start is issued (-1 = never).
   task automatic do_load(input logic [31:0] base, input int nw, input int abort_at,
                          input int gap_mode, input int restart_at, input string name);
      int k = 0, n_w = 0;
      logic xfer_pending = 1'b0, prev_abort = 1'b0, prev_last = 1'b0;
      logic first = 1'b1, aborted = 1'b0, restarted = 1'b0, finished = 1'b0, tog = 1'b0;
      logic exp_mw, exp_done, exp_ready, exp_wrap;
      logic [31:0] ea, ed;
      got_a.delete();
      got_d.delete();
      @(posedge clk); #1;
      start = 1'b1; base_adrr = base; num_words = nw[15:0]; in_valid = 1'b0; abort = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         if (first) begin
            total++;
            if (wrap_err !== 1'b0 || words_written !== 16'd0) begin
               bad++;
               $display("FAIL %s start_clear: wrap_err=%b words_written=%0d want 0/0", name, wrap_err, words_written);
            end
         end
         if (xfer_pending) k++;
         exp_mw = xfer_pending && (k % 4 == 0);
         if (exp_mw) n_w++;
         exp_done  = prev_abort || prev_last || (first && nw == 0);
         exp_ready = !exp_done && !exp_mw;
         total++;
         if (m_w !== exp_mw) begin
            bad++;
            $display("FAIL %s m_w: got %b want %b (bytes=%0d)", name, m_w, exp_mw, k);
         end
         if (m_w === 1'b1) begin
            got_a.push_back(w_adrr);
            got_d.push_back(w_data);
         end
         total++;
         if (done !== exp_done) begin
            bad++;
            $display("FAIL %s done: got %b want %b (bytes=%0d)", name, done, exp_done, k);
         end
         total++;
         if ({busy, cpu_hold, in_ready} !== {!exp_done, !exp_done, exp_ready}) begin
            bad++;
            $display("FAIL %s busy/hold/ready: got %b%b%b want %b%b%b", name, busy, cpu_hold, in_ready,
                     !exp_done, !exp_done, exp_ready);
         end
         prev_last  = exp_mw && (n_w == nw);
         prev_abort = 1'b0;
         in_valid   = 1'b0;
         if (exp_done) begin
            finished = 1'b1;
         end else begin
            if (restart_at >= 0 && !restarted && k >= restart_at) begin
               start = 1'b1; base_adrr = base + 32'h40; num_words = 16'(nw + 5); restarted = 1'b1;
            end
            if (abort_at >= 0 && !aborted && k >= abort_at) begin
               abort = 1'b1; aborted = 1'b1; prev_abort = 1'b1;
            end else if (!aborted && k < 4 * nw) begin
               tog = ~tog;
               case (gap_mode)
                  0:       in_valid = 1'b1;
                  1:       in_valid = 1'($urandom_range(0, 1));
                  default: in_valid = tog;
               endcase
               in_data = stim[k];
            end
         end
         xfer_pending = in_valid && exp_ready;
         first = 1'b0;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      total++;
      if (!finished) begin
         bad++;
         $display("FAIL %s timeout: no completion within cycle budget", name);
      end
      // Final write list, counters and the sticky wrap flag.
      exp_wrap = 1'b0;
      total++;
      if (got_a.size() != n_w) begin
         bad++;
         $display("FAIL %s write_count: got %0d want %0d", name, got_a.size(), n_w);
      end else begin
         for (int i = 0; i < n_w; i++) begin
            ea = ((base & ~32'd3) + 32'(4 * i)) % 32'(DEPTH * 4);
            ed = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
            if (ea == 32'(DEPTH * 4 - 4)) exp_wrap = 1'b1;
            total++;
            if (got_a[i] !== ea || got_d[i] !== ed) begin
               bad++;
               $display("FAIL %s write%0d: got %h:%h want %h:%h", name, i, got_a[i], got_d[i], ea, ed);
            end
         end
      end
      total++;
      if (words_written !== 16'(n_w) || wrap_err !== exp_wrap) begin
         bad++;
         $display("FAIL %s final: words_written=%0d wrap_err=%b want %0d/%b", name, words_written, wrap_err,
                  n_w, exp_wrap);
      end
      @(posedge clk); #1;
      total++;
      if ({done, busy, m_w, in_ready} !== 4'b0000) begin
         bad++;
         $display("FAIL %s idle_after: done/busy/m_w/ready=%b%b%b%b want 0000", name, done, busy, m_w, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base_adrr = 32'h0; num_words = 16'h0;
      abort = 1'b0; in_valid = 1'b0; in_data = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({in_ready, m_w, cpu_hold, busy, done, wrap_err} !== 6'b0 || w_adrr !== 32'h0 ||
          w_data !== 32'h0 || words_written !== 16'h0) begin
         bad++;
         $display("FAIL reset: flags=%b adr=%h data=%h ww=%0d want all zero",
                  {in_ready, m_w, cpu_hold, busy, done, wrap_err}, w_adrr, w_data, words_written);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] prog [0:7];
      prog = '{8'h8C, 8'h43, 8'h00, 8'h02, 8'h00, 8'hC3, 8'h20, 8'h20};
      for (int i = 0; i < 8; i++) stim[i] = prog[i];
      do_load(32'h0, 2, -1, 0, -1, "basic");
      total++;
      if (got_d.size() != 2 || got_d[0] !== 32'h8C430002 || got_d[1] !== 32'h00C32020 ||
          got_a[0] !== 32'h0 || got_a[1] !== 32'h4) begin
         bad++;
         $display("FAIL basic_words: got %0d writes, want 0:8c430002 4:00c32020", got_d.size());
      end
   endtask

   task automatic test_backpressure();
      fill_random();
      do_load(32'h13, 1, -1, 2, -1, "backpressure");
      total++;
      if (got_a.size() != 1 || got_a[0] !== 32'h10) begin
         bad++;
         $display("FAIL backpressure_addr: writes=%0d want one write at 00000010", got_a.size());
      end
   endtask

   task automatic test_wrap();
      fill_random();
      do_load(32'h3FC, 2, -1, 1, -1, "wrap");
      total++;
      if (got_a.size() != 2 || got_a[0] !== 32'h3FC || got_a[1] !== 32'h0) begin
         bad++;
         $display("FAIL wrap_addr: writes=%0d want 000003fc then 00000000", got_a.size());
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (wrap_err !== 1'b1) begin
         bad++;
         $display("FAIL wrap_sticky: got %b want 1", wrap_err);
      end
   endtask

   task automatic test_abort();
      fill_random();
      do_load(32'h100, 3, 6, 1, -1, "abort_collect");
      fill_random();
      do_load(32'h200, 1, -1, 0, -1, "after_abort");
      fill_random();
      do_load(32'h80, 3, 4, 0, -1, "abort_write");
   endtask

   task automatic test_zero_words();
      do_load(32'h40, 0, -1, 0, -1, "zero_words");
   endtask

   task automatic test_start_ignored();
      fill_random();
      do_load(32'h40, 1, -1, 0, 2, "start_ignored");
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         fill_random();
         do_load(32'($urandom_range(0, DEPTH * 4 - 1)), $urandom_range(1, 4), -1, 1, -1, "random");
      end
   endtask

   task automatic test_reset_mid();
      fill_random();
      @(posedge clk); #1;
      start = 1'b1; base_adrr = 32'h20; num_words = 16'd2;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = stim[i];
         @(posedge clk); #1;
         total++;
         if (m_w !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_stream: m_w=%b want 0 at byte %0d", m_w, i);
         end
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++;
      if ({in_ready, m_w, cpu_hold, busy, done, wrap_err} !== 6'b0 || w_adrr !== 32'h0 ||
          w_data !== 32'h0 || words_written !== 16'h0) begin
         bad++;
         $display("FAIL reset_mid: flags=%b adr=%h data=%h ww=%0d want all zero",
                  {in_ready, m_w, cpu_hold, busy, done, wrap_err}, w_adrr, w_data, words_written);
      end
      @(posedge clk); #1;
      total++;
      if (m_w !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_after: m_w=%b busy=%b want 0/0", m_w, busy);
      end
      fill_random();
      do_load(32'h0, 1, -1, 0, -1, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_abort();
      test_zero_words();
      test_start_ignored();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
Write-side companion to the instruction memory read port. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS instruction words, and writes them into instruction memory at consecutive word addresses from a programmable base. While loading, it holds the pipeline (cpu_hold) so instruction fetch never reads a half-loaded program.

Parameters:
DEPTH, 256, instruction memory depth in words (power of two)
AW, 32, byte-address width driven on w_adrr

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a load (sampled only in IDLE)
base_adrr  input  AW  byte address of first word; bits [1:0] ignored (forced 0)
num_words  input  16  words to load; sampled with start
abort  input  1  terminates the load at the next cycle edge
in_valid  input  1  byte-stream valid
in_data  input  8  stream byte, MSB-first within each word
in_ready  output  1  loader can accept a byte this cycle
w_adrr  output  AW  byte write address (word aligned)
w_data  output  32  assembled instruction word
m_w  output  1  one-cycle write strobe to instruction memory
cpu_hold  output  1  high while not IDLE/DONE; stalls fetch
busy  output  1  load in progress
done  output  1  one-cycle pulse when the load completes or aborts
wrap_err  output  1  sticky; address wrapped past DEPTH*4-4
words_written  output  16  count of m_w strobes in the current load

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; in_ready, m_w, cpu_hold, busy, done, wrap_err = 0; w_adrr, w_data, words_written = 0; byte counter = 0. Reset mid-load drops the partial word and issues no write.
- FSM states: IDLE, COLLECT, WRITE, FINISH.
- IDLE: start=1 -> latch base_adrr & ~3 into the address register, latch num_words, clear words_written and wrap_err, then go to COLLECT. If num_words=0, go directly to FINISH. Start while not in IDLE is ignored.
- COLLECT: in_ready=1. A byte transfers when in_valid & in_ready. Byte k (k=0..3) goes to w_data[31-8k -: 8]; byte 0 is the MSB. On the 4th transfer, go to WRITE.
- WRITE, exactly 1 cycle: m_w=1; w_adrr = current address; w_data is stable; in_ready=0.
  - Next edge: words_written+1; address +4 modulo DEPTH*4.
  - If the address was DEPTH*4-4, it wraps to 0 and wrap_err is set (sticky until the next start).
  - If words_written+1 == num_words, go to FINISH; otherwise go to COLLECT.
- FINISH, 1 cycle: done=1; busy=0; cpu_hold=0; next state IDLE.
- busy and cpu_hold are 1 in COLLECT and WRITE, 0 otherwise.
- Latency: m_w asserts in the cycle after the 4th byte handshake. Peak throughput is one word per 5 cycles.
- abort=1 in COLLECT: discard partial bytes and go to FINISH.
- abort=1 in WRITE: the current write completes (m_w still pulses, count increments), then go to FINISH.
- abort is ignored in IDLE and FINISH.
- in_valid with in_ready=0 transfers nothing; the source holds its data.
- m_w is never asserted outside WRITE. w_adrr always has bits [1:0] = 0.

Test Plan:
1. Reset then start, base_adrr=0, num_words=2; stream 8C,43,00,02,00,C3,20,20.
   - m_w pulses twice: w_adrr=0x0, w_data=0x8C430002; then w_adrr=0x4, w_data=0x00C32020.
   - done pulses 2 cycles after the last byte; words_written=2.
2. Backpressure: in_valid toggles 1/0 every cycle, num_words=1, base_adrr=0x13.
   - Single write at w_adrr=0x10 with the correct word.
   - in_ready=0 during WRITE; no byte is lost or duplicated.
3. Wrap: base_adrr=0x3FC, num_words=2.
   - Writes occur at 0x3FC then 0x000; wrap_err=1 after the first write and stays high until the next start.
4. Abort mid-word: after 2 bytes of the 2nd word, assert abort.
   - Exactly one m_w; done pulses; words_written=1.
   - A later start with num_words=1 loads cleanly from byte 0.
5. num_words=0 start -> no m_w; done pulses on the 2nd cycle after start; cpu_hold stays 0.
6. rst_n low during COLLECT after 3 bytes -> no m_w; all outputs return to reset values the next cycle; start is ignored while busy (a second start mid-load leaves base/count unchanged).
